// File: rtl/cache_pkg.sv
// Shared types and address helpers for the set-associative cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WAIT,
        MEM_WR,
        RESP
    } state_t;

    localparam int DEFAULT_WAYS  = 4;
    localparam int DEFAULT_AGE_W = $clog2(DEFAULT_WAYS);

    function automatic int age_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Word index: the two byte-offset bits sit below the index field.
    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w);
        return (addr >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w);
        return addr >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/cache_lru_ctrl.sv
// True-LRU age tracking per set, victim choice and update-on-access.
module cache_lru_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 256,
    parameter int IDX_W = 8,
    parameter int AGE_W = age_width(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    input  logic [WAYS-1:0]  valid_vec,
    output logic [AGE_W-1:0] victim,
    input  logic             upd_en,
    input  logic [AGE_W-1:0] upd_way
);

    logic [AGE_W-1:0] age [SETS][WAYS];
    logic             found_invalid;

    // An empty way always beats evicting live data; otherwise take the oldest.
    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_vec[w]) begin
                victim        = AGE_W'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[idx][w] == AGE_W'(WAYS - 1)) begin
                    victim = AGE_W'(w);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= AGE_W'(w);
                end
            end
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[idx][w] < age[idx][upd_way]) begin
                    age[idx][w] <= age[idx][w] + AGE_W'(1);
                end
            end
            age[idx][upd_way] <= '0;
        end
    end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative, write-through/write-allocate cache controller
// with one word per line, true-LRU replacement and a memory miss-fill path.
module set_assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAYS   = 4,
    parameter int SETS   = 256,
    parameter int IDX_W  = $clog2(SETS),
    parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int AGE_W = age_width(WAYS);

    state_t            state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hit_q;
    logic [AGE_W-1:0]  victim_q;

    logic [WAYS-1:0]   valid_q  [SETS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS];

    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic [WAYS-1:0]   hit_vec;
    logic              hit_any;
    logic [AGE_W-1:0]  hit_way;
    logic [AGE_W-1:0]  victim;

    logic              lru_upd;
    logic [AGE_W-1:0]  lru_way;
    logic              arr_we;
    logic [AGE_W-1:0]  arr_way;
    logic [DATA_W-1:0] arr_data;

    assign cur_idx = IDX_W'(addr_index(64'(addr_q), IDX_W));
    assign cur_tag = TAG_W'(addr_tag(64'(addr_q), IDX_W));

    // Descending scan so the lowest matching way wins if tags ever alias.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[cur_idx][w] && (tag_mem[cur_idx][w] == cur_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = AGE_W'(w);
            end
        end
        hit_any = |hit_vec;
    end

    always_comb begin
        lru_upd  = 1'b0;
        lru_way  = '0;
        arr_we   = 1'b0;
        arr_way  = '0;
        arr_data = wdata_q;
        case (state)
            LOOKUP: begin
                if (hit_any) begin
                    lru_upd = 1'b1;
                    lru_way = hit_way;
                    arr_we  = we_q;
                    arr_way = hit_way;
                end else if (we_q) begin
                    lru_upd = 1'b1;
                    lru_way = victim;
                    arr_we  = 1'b1;
                    arr_way = victim;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    lru_upd  = 1'b1;
                    lru_way  = victim_q;
                    arr_we   = 1'b1;
                    arr_way  = victim_q;
                    arr_data = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    cache_lru_ctrl #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .AGE_W (AGE_W)
    ) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (cur_idx),
        .valid_vec (valid_q[cur_idx]),
        .victim    (victim),
        .upd_en    (lru_upd),
        .upd_way   (lru_way)
    );

    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[cur_idx][arr_way]  <= cur_tag;
            data_mem[cur_idx][arr_way] <= arr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_hit      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            hit_q         <= 1'b0;
            victim_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            if (arr_we) begin
                valid_q[cur_idx][arr_way] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q    <= hit_any;
                    victim_q <= victim;
                    if (we_q) begin
                        mem_req_valid <= 1'b1;
                        mem_we        <= 1'b1;
                        mem_addr      <= {addr_q[ADDR_W-1:2], 2'b00};
                        mem_wdata     <= wdata_q;
                        state         <= MEM_WR;
                    end else if (hit_any) begin
                        resp_rdata <= data_mem[cur_idx][hit_way];
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= {addr_q[ADDR_W-1:2], 2'b00};
                        state         <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        resp_rdata <= mem_rdata;
                        resp_valid <= 1'b1;
                        resp_hit   <= hit_q;
                        state      <= RESP;
                    end
                end
                MEM_WR: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_we        <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_hit      <= hit_q;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_hit   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
